// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // N: number of digit passes per operation
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when a single pass covers the word
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// DIGIT-bit ripple chain of full-adder cells; exposes the carry into the top bit
// so the parent can form two's-complement overflow.
module fa_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] c_s;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        full_add = {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

    // Ripple the carry through the chain of cells
    always_comb begin
        c_s    = {(DIGIT+1){1'b0}};
        s      = {DIGIT{1'b0}};
        c_s[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            {c_s[i+1], s[i]} = full_add(a[i], b[i], c_s[i]);
        end
    end

    assign co    = c_s[DIGIT];
    assign c_top = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock with a registered inter-digit carry.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for a-b via ~b and carry-in of 1.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int N     = num_digits(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   dsum_s;
    logic               dco_s;
    logic               dctop_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]   b_load_s;
    logic               carry_load_s;

    fa_digit #(.DIGIT(DIGIT)) u_fa_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dsum_s),
        .co    (dco_s),
        .c_top (dctop_s)
    );

    // New digit enters at the MSB; after N passes digit 0 sits at the bottom
    assign acc_next_s = WIDTH'({dsum_s, acc_q} >> DIGIT);

    // Operand conditioning at capture time
    always_comb begin
        b_load_s     = b;
        carry_load_s = ci;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = ci;
        end
`endif
    end

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load_s;
                    carry_d = carry_load_s;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dco_s;
                acc_d   = acc_next_s;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = {CNT_W{1'b0}};
                    s_d     = acc_next_s;
                    co_d    = dco_s;
                    ovf_d   = dco_s ^ dctop_s;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            acc_q   <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: four instances (8/1, 8/4, 2/1, 2/2) sharing clock and reset.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0] start_r = 4'b0000;
    logic [3:0] ci_r    = 4'b0000;
    logic [7:0] a8 [2];
    logic [7:0] b8 [2];
    logic [1:0] a2 [2];
    logic [1:0] b2 [2];
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_r = 1'b0;
`endif

    logic [3:0] busy_w, done_w, co_w, ovf_w;
    logic [7:0] s0, s1;
    logic [1:0] s2, s3;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .a(a8[0]), .b(b8[0]), .ci(ci_r[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_r),
`endif
        .busy(busy_w[0]), .done(done_w[0]), .s(s0), .co(co_w[0]), .ovf(ovf_w[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_8d4 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .a(a8[1]), .b(b8[1]), .ci(ci_r[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy_w[1]), .done(done_w[1]), .s(s1), .co(co_w[1]), .ovf(ovf_w[1]));

    serial_adder #(.WIDTH(2), .DIGIT(1)) u_2d1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .a(a2[0]), .b(b2[0]), .ci(ci_r[2]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy_w[2]), .done(done_w[2]), .s(s2), .co(co_w[2]), .ovf(ovf_w[2]));

    serial_adder #(.WIDTH(2), .DIGIT(2)) u_2d2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[3]), .a(a2[1]), .b(b2[1]), .ci(ci_r[3]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy_w[3]), .done(done_w[3]), .s(s3), .co(co_w[3]), .ovf(ovf_w[3]));

    function automatic logic [7:0] s_of(input logic [1:0] inst);
        case (inst)
            2'd0:    s_of = s0;
            2'd1:    s_of = s1;
            2'd2:    s_of = {6'b0, s2};
            default: s_of = {6'b0, s3};
        endcase
    endfunction

    task automatic drive_ops(input logic [1:0] inst, input logic [7:0] av, input logic [7:0] bv, input logic civ);
        if (inst[1] == 1'b0) begin
            a8[inst[0]] = av;
            b8[inst[0]] = bv;
        end else begin
            a2[inst[0]] = av[1:0];
            b2[inst[0]] = bv[1:0];
        end
        ci_r[inst] = civ;
    endtask

    // Start in the current cycle, return at the negedge of the done cycle
    task automatic run_op(input logic [1:0] inst, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, output int cyc, output int bcnt);
        drive_ops(inst, av, bv, civ);
        start_r[inst] = 1'b1;
        @(negedge clk);
        start_r[inst] = 1'b0;
        cyc  = 1;
        bcnt = 0;
        while (done_w[inst] !== 1'b1 && cyc < 40) begin
            if (busy_w[inst] === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy_w[i], done_w[i], co_w[i], ovf_w[i], s_of(2'(i))} !== 12'h000) begin
                failures++;
                $display("FAIL reset_state inst=%0d: got busy/done/co/ovf/s=%b%b%b%b/%h expected 0000/00",
                         i, busy_w[i], done_w[i], co_w[i], ovf_w[i], s_of(2'(i)));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_bit_serial();
        int cyc, bcnt;
        run_op(2'd0, 8'hFF, 8'h01, 1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 9) begin failures++; $display("FAIL d1_latency: got %0d expected 9", cyc); end
        checks++;
        if (bcnt !== 8) begin failures++; $display("FAIL d1_busy_cycles: got %0d expected 8", bcnt); end
        checks++;
        if ({s0, co_w[0], ovf_w[0]} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL d1_ff_plus_01: got s=%h co=%b ovf=%b expected s=00 co=1 ovf=0", s0, co_w[0], ovf_w[0]);
        end
        @(negedge clk);
        checks++;
        if ({done_w[0], busy_w[0], s0} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL d1_done_pulse: got done=%b busy=%b s=%h expected 0 0 00", done_w[0], busy_w[0], s0);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        drive_ops(2'd0, 8'h7F, 8'h01, 1'b1);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        for (cyc = 1; cyc < 40 && done_w[0] !== 1'b1; cyc++) begin
            if (cyc == 3) begin
                drive_ops(2'd0, 8'h11, 8'h22, 1'b0);
                start_r[0] = 1'b1;
            end
            if (cyc == 5) begin
                start_r[0] = 1'b0;
                checks++;
                if (s0 !== 8'h00) begin failures++; $display("FAIL d1_s_held_in_run: got %h expected 00", s0); end
            end
            @(negedge clk);
        end
        checks++;
        if (cyc !== 9) begin failures++; $display("FAIL d1_ignored_latency: got %0d expected 9", cyc); end
        checks++;
        if ({s0, co_w[0], ovf_w[0]} !== {8'h81, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL d1_7f_plus_01_ci: got s=%h co=%b ovf=%b expected s=81 co=0 ovf=1", s0, co_w[0], ovf_w[0]);
        end
        @(negedge clk);
        checks++;
        if ({busy_w[0], done_w[0], s0} !== {1'b0, 1'b0, 8'h81}) begin
            failures++;
            $display("FAIL d1_ignored_start_idle: got busy=%b done=%b s=%h expected 0 0 81", busy_w[0], done_w[0], s0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        run_op(2'd1, 8'hA5, 8'h5B, 1'b1, cyc, bcnt);
        checks++;
        if (cyc !== 3) begin failures++; $display("FAIL d4_latency: got %0d expected 3", cyc); end
        checks++;
        if ({s1, co_w[1], ovf_w[1]} !== {8'h01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL d4_a5_plus_5b: got s=%h co=%b ovf=%b expected s=01 co=1 ovf=0", s1, co_w[1], ovf_w[1]);
        end
        drive_ops(2'd1, 8'h12, 8'h34, 1'b0);
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        checks++;
        if ({busy_w[1], done_w[1], s1} !== {1'b1, 1'b0, 8'h01}) begin
            failures++;
            $display("FAIL d4_b2b_accept: got busy=%b done=%b s=%h expected 1 0 01", busy_w[1], done_w[1], s1);
        end
        cyc = 1;
        while (done_w[1] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 3) begin failures++; $display("FAIL d4_b2b_latency: got %0d expected 3", cyc); end
        checks++;
        if ({s1, co_w[1], ovf_w[1]} !== {8'h46, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL d4_b2b_result: got s=%h co=%b ovf=%b expected s=46 co=0 ovf=0", s1, co_w[1], ovf_w[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int cyc, bcnt;
        drive_ops(2'd0, 8'h3C, 8'h0F, 1'b0);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_w[0], done_w[0], co_w[0], ovf_w[0], s0, s1} !== 20'h00000) begin
            failures++;
            $display("FAIL async_reset_mid_run: got busy=%b done=%b co=%b ovf=%b s=%h s_d4=%h expected all 0",
                     busy_w[0], done_w[0], co_w[0], ovf_w[0], s0, s1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'd0, 8'h3C, 8'h0F, 1'b0, cyc, bcnt);
        checks++;
        if ({cyc[7:0], s0, co_w[0], ovf_w[0]} !== {8'd9, 8'h4B, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_op: got cyc=%0d s=%h co=%b ovf=%b expected 9 4b 0 0", cyc, s0, co_w[0], ovf_w[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive_w2();
        int cyc, bcnt;
        logic [2:0] exp_sum;
        logic [1:0] xa, yb;
        logic       exp_ovf;
        for (int inst = 2; inst < 4; inst++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 4; x++) begin
                    for (int y = 0; y < 4; y++) begin
                        xa      = 2'(x);
                        yb      = 2'(y);
                        exp_sum = {1'b0, xa} + {1'b0, yb} + 3'(c);
                        exp_ovf = (xa[1] == yb[1]) && (exp_sum[1] != xa[1]);
                        run_op(2'(inst), {6'b0, xa}, {6'b0, yb}, c[0], cyc, bcnt);
                        checks++;
                        if (cyc !== ((inst == 2) ? 3 : 2)) begin
                            failures++;
                            $display("FAIL w2_latency inst=%0d: got %0d expected %0d", inst, cyc, (inst == 2) ? 3 : 2);
                        end
                        checks++;
                        if ({s_of(2'(inst)), co_w[inst], ovf_w[inst]} !== {6'b0, exp_sum[1:0], exp_sum[2], exp_ovf}) begin
                            failures++;
                            $display("FAIL w2_sum inst=%0d a=%0d b=%0d ci=%0d: got s=%h co=%b ovf=%b expected s=%h co=%b ovf=%b",
                                     inst, x, y, c, s_of(2'(inst)), co_w[inst], ovf_w[inst],
                                     exp_sum[1:0], exp_sum[2], exp_ovf);
                        end
                    end
                end
            end
            @(negedge clk);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int cyc, bcnt;
        sub_r = 1'b1;
        run_op(2'd0, 8'h05, 8'h07, 1'b0, cyc, bcnt);
        checks++;
        if ({s0, co_w[0], ovf_w[0]} !== {8'hFE, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_05_minus_07: got s=%h co=%b ovf=%b expected s=fe co=0 ovf=0", s0, co_w[0], ovf_w[0]);
        end
        run_op(2'd0, 8'h80, 8'h01, 1'b0, cyc, bcnt);
        checks++;
        if ({s0, co_w[0], ovf_w[0]} !== {8'h7F, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_80_minus_01: got s=%h co=%b ovf=%b expected s=7f co=1 ovf=1", s0, co_w[0], ovf_w[0]);
        end
        sub_r = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 2; i++) begin
            a8[i] = 8'h00;
            b8[i] = 8'h00;
            a2[i] = 2'b00;
            b2[i] = 2'b00;
        end
        test_reset();
        test_add_bit_serial();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive_w2();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
